// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder between the CPU request logic and a single-ported,
//   variable-latency RAM. Instruction reads (iREN) and data reads/writes
//   (dmemREN/dmemWEN) are serialised onto the RAM one at a time. Each access
//   completes with a registered one-cycle ihit or dhit pulse and, for reads,
//   registered load data. An access that sees ramstate=ERROR, or that waits
//   TIMEOUT cycles without ACCESS, is aborted. It returns ERRDATA and sets
//   the sticky merr flag.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        instruction read request (held until ihit) and address
//   iload, ihit        instruction data and one-cycle completion pulse
//   dmemREN, dmemWEN   data read / write request (held until dhit)
//   daddr, dstore      data address and write value
//   dload, dhit        data read value and one-cycle completion pulse
//   ramaddr, ramstore  RAM address and write data
//   ramREN, ramWEN     RAM strobes, constant for the whole access
//   ramload, ramstate  RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   merr               sticky error flag, cleared only by reset
module mem_responder #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merr
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;
    typedef enum logic {LAST_INSTR, LAST_DATA} last_t;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    state_t      state, state_n;
    last_t       last, last_n;
    ramstate_t   rs;
    logic [4:0]  cnt, cnt_n;
    logic        ihit_n, dhit_n, merr_n;
    logic        ramREN_n, ramWEN_n;
    logic [31:0] iload_n, dload_n, ramaddr_n, ramstore_n;
    logic        abort, finish;

    always_comb begin
        rs = ramstate_t'(ramstate);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            last     <= LAST_INSTR;
            cnt      <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            merr     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            cnt      <= cnt_n;
            ihit     <= ihit_n;
            dhit     <= dhit_n;
            merr     <= merr_n;
            ramREN   <= ramREN_n;
            ramWEN   <= ramWEN_n;
            iload    <= iload_n;
            dload    <= dload_n;
            ramaddr  <= ramaddr_n;
            ramstore <= ramstore_n;
        end
    end

    always_comb begin
        state_n    = state;
        last_n     = last;
        cnt_n      = cnt;
        ihit_n     = 1'b0;
        dhit_n     = 1'b0;
        merr_n     = merr;
        ramREN_n   = ramREN;
        ramWEN_n   = ramWEN;
        iload_n    = iload;
        dload_n    = dload;
        ramaddr_n  = ramaddr;
        ramstore_n = ramstore;
        abort      = 1'b0;
        finish     = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless the previous service was also data and an
                // instruction fetch is waiting; this alternates under contention.
                if ((dmemREN || dmemWEN) && (!iREN || last == LAST_INSTR)) begin
                    state_n    = DACC;
                    ramaddr_n  = daddr;
                    ramstore_n = dstore;
                    ramWEN_n   = dmemWEN;
                    ramREN_n   = !dmemWEN;
                end else if (iREN) begin
                    state_n   = IACC;
                    ramaddr_n = iaddr;
                    ramREN_n  = 1'b1;
                    ramWEN_n  = 1'b0;
                end
            end

            DACC, IACC: begin
                if (cnt != '1) begin
                    cnt_n = cnt + 5'd1;
                end
                abort  = (rs == RAM_ERROR) || (rs != RAM_ACCESS && cnt == CNT_LAST);
                finish = (rs == RAM_ACCESS) || abort;
                if (finish) begin
                    state_n  = RESP;
                    ramREN_n = 1'b0;
                    ramWEN_n = 1'b0;
                    if (abort) begin
                        merr_n = 1'b1;
                    end
                    if (state == IACC) begin
                        ihit_n  = 1'b1;
                        last_n  = LAST_INSTR;
                        iload_n = abort ? ERRDATA : ramload;
                    end else begin
                        dhit_n = 1'b1;
                        last_n = LAST_DATA;
                        // An aborted write also reports ERRDATA on dload.
                        if (abort) begin
                            dload_n = ERRDATA;
                        end else if (ramREN) begin
                            dload_n = ramload;
                        end
                    end
                end
            end

            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Randomised self-checking bench for mem_responder. The bench plays both
//   the CPU requester and the RAM. A sparse-array memory model supplies read
//   data and absorbs writes. Expected latency, load values and the sticky
//   error flag are computed from the access rules at transaction level.
module tb_mem_responder;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] ERRDATA = 32'hBAD1BAD1;
    localparam logic [1:0]  FREE    = 2'd0;
    localparam logic [1:0]  BUSY    = 2'd1;
    localparam logic [1:0]  ACCESS  = 2'd2;
    localparam logic [1:0]  ERROR   = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        ihit;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dhit;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = FREE;
    logic        merr;

    mem_responder #(
        .TIMEOUT(TIMEOUT),
        .ERRDATA(ERRDATA)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .iREN(iREN),
        .iaddr(iaddr),
        .iload(iload),
        .ihit(ihit),
        .dmemREN(dmemREN),
        .dmemWEN(dmemWEN),
        .daddr(daddr),
        .dstore(dstore),
        .dload(dload),
        .dhit(dhit),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramload(ramload),
        .ramstate(ramstate),
        .merr(merr)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_iload = '0;
    logic [31:0] exp_dload = '0;
    logic        exp_merr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // One isolated request. k = non-ACCESS cycles before the RAM responds;
    // use_err makes that response ERROR instead of ACCESS.
    task automatic access(input bit is_i, input bit is_w, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned k, input bit use_err);
        int unsigned exp_lat;
        int unsigned strobe_cyc;
        bit          aborted;
        bit          done;
        bit          rd;
        rd = is_i || !is_w;
        if (k + 1 <= TIMEOUT) begin
            exp_lat = k + 2;
            aborted = use_err;
        end else begin
            exp_lat = TIMEOUT + 1;
            aborted = 1'b1;
        end
        @(negedge CLK);
        iREN     = is_i;
        dmemREN  = !is_i && !is_w;
        dmemWEN  = !is_i && is_w;
        iaddr    = is_i ? addr : $urandom;
        daddr    = is_i ? $urandom : addr;
        dstore   = wdata;
        ramstate = FREE;
        ramload  = $urandom;
        done       = 1'b0;
        strobe_cyc = 0;
        for (int unsigned c = 1; c <= TIMEOUT + 8 && !done; c++) begin
            @(negedge CLK);
            if (ihit || dhit) begin
                done = 1'b1;
                if (aborted) exp_merr = 1'b1;
                if (is_i) exp_iload = aborted ? ERRDATA : mem_rd(addr);
                else if (aborted) exp_dload = ERRDATA;
                else if (!is_w) exp_dload = mem_rd(addr);
                check("hit_latency", 32'(c), 32'(exp_lat));
                check("hit_port", 32'({ihit, dhit}), is_i ? 32'd2 : 32'd1);
                check("iload", iload, exp_iload);
                check("dload", dload, exp_dload);
                check("merr", 32'(merr), 32'(exp_merr));
                check("resp_strobes", 32'({ramREN, ramWEN}), 32'd0);
                check("strobe_cycles", 32'(strobe_cyc), 32'(exp_lat - 1));
                iREN     = 1'b0;
                dmemREN  = 1'b0;
                dmemWEN  = 1'b0;
                ramstate = FREE;
            end else begin
                if (ramREN || ramWEN) strobe_cyc++;
                check("ramREN", 32'(ramREN), 32'(rd));
                check("ramWEN", 32'(ramWEN), 32'(!rd));
                check("ramaddr", ramaddr, addr);
                if (!rd) check("ramstore", ramstore, wdata);
                if (c - 1 < k) begin
                    ramstate = ($urandom_range(0, 1) == 1) ? BUSY : FREE;
                    ramload  = $urandom;
                end else if (use_err) begin
                    ramstate = ERROR;
                    ramload  = $urandom;
                end else begin
                    ramstate = ACCESS;
                    ramload  = mem_rd(ramaddr);
                    if (ramWEN) mem[ramaddr] = ramstore;
                end
            end
        end
        if (!done) check("hit_timeout", 32'(done), 32'd1);
        @(negedge CLK);
        check("hit_pulse_end", 32'({ihit, dhit}), 32'd0);
        check("idle_strobes", 32'({ramREN, ramWEN}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned nh;
        logic [31:0] a_i, a_d;
        logic [31:0] pool [4];
        bit          want_d;

        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h10C;

        repeat (2) @(negedge CLK);
        check("rst_hits", 32'({ihit, dhit}), 32'd0);
        check("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        check("rst_merr", 32'(merr), 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        nRST = 1'b1;

        mem[32'h40] = 32'hDEADBEEF;
        access(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0);
        access(1'b0, 1'b1, 32'h80, 32'h12345678, 3, 1'b0);
        access(1'b0, 1'b0, 32'h80, 32'h0, 1, 1'b0);
        access(1'b0, 1'b0, 32'h44, 32'h0, 20, 1'b0);
        access(1'b1, 1'b0, 32'h200, 32'h0, 2, 1'b1);
        access(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0);
        access(1'b1, 1'b0, 32'h204, 32'h0, 15, 1'b0);

        // Contention: both requests held, zero-wait RAM; expect D, I, D, I.
        a_i = 32'h300;
        a_d = 32'h340;
        @(negedge CLK);
        iREN = 1'b1; iaddr = a_i;
        dmemREN = 1'b1; dmemWEN = 1'b0; daddr = a_d;
        ramstate = FREE;
        nh = 0;
        for (int unsigned c = 1; c <= 20 && nh < 4; c++) begin
            @(negedge CLK);
            check("hit_overlap", 32'(ihit && dhit), 32'd0);
            check("strobe_overlap", 32'(ramREN && ramWEN), 32'd0);
            if (ihit || dhit) begin
                want_d = (nh % 2) == 0;
                if (want_d) exp_dload = mem_rd(a_d);
                else exp_iload = mem_rd(a_i);
                check("arb_order", 32'({ihit, dhit}), want_d ? 32'd1 : 32'd2);
                check("arb_cycle", 32'(c), 32'(2 + 3 * nh));
                check("arb_iload", iload, exp_iload);
                check("arb_dload", dload, exp_dload);
                check("arb_merr", 32'(merr), 32'(exp_merr));
                nh++;
                ramstate = FREE;
            end else if (ramREN) begin
                ramstate = ACCESS;
                ramload  = mem_rd(ramaddr);
            end else begin
                ramstate = FREE;
                ramload  = $urandom;
            end
        end
        check("arb_hits", 32'(nh), 32'd4);
        iREN = 1'b0; dmemREN = 1'b0;
        @(negedge CLK);

        // Reset during the second cycle of a five-cycle data read.
        @(negedge CLK);
        dmemREN = 1'b1; daddr = 32'h48; ramstate = FREE;
        @(negedge CLK);
        check("pre_rst_ramREN", 32'(ramREN), 32'd1);
        ramstate = BUSY;
        @(negedge CLK);
        check("pre_rst_ramREN2", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        check("mid_rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        check("mid_rst_hits", 32'({ihit, dhit}), 32'd0);
        check("mid_rst_merr", 32'(merr), 32'd0);
        exp_merr = 1'b0; exp_iload = '0; exp_dload = '0;
        dmemREN = 1'b0; ramstate = ACCESS;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("post_rst_hits", 32'({ihit, dhit}), 32'd0);
            check("post_rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        end
        ramstate = FREE;
        check("post_rst_dload", dload, 32'd0);
        access(1'b0, 1'b0, 32'h48, 32'h0, 2, 1'b0);

        for (int unsigned n = 0; n < 40; n++) begin
            bit          ri, rw, re;
            int unsigned rk;
            ri = $urandom_range(0, 2) == 0;
            rw = $urandom_range(0, 1) == 1;
            re = $urandom_range(0, 7) == 0;
            rk = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 19) : $urandom_range(0, 5);
            access(ri, rw, pool[$urandom_range(0, 3)], $urandom, rk, re);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
